frame_stream_tx: RTL and testbench
==================================

FRAME_STREAM_TX -- requirements
Module: frame_stream_tx

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  one-cycle request to transmit one frame.
REQ-004 SHALL have port: cont  input  1  continuous mode; sampled at frame end.
REQ-005 SHALL have port: width  input  11  pixels per line, sampled on accepted start.
REQ-006 SHALL have port: height  input  10  lines per frame, sampled on accepted start.
REQ-007 SHALL have port: pix_valid  input  1  upstream pixel valid.
REQ-008 SHALL have port: pix_ready  output  1  upstream pixel accepted when pix_valid && pix_ready.
REQ-009 SHALL have port: pix_data  input  8  upstream pixel.
REQ-010 SHALL have port: m_valid  output  1  AXI-Stream TVALID.
REQ-011 SHALL have port: m_ready  input  1  AXI-Stream TREADY.
REQ-012 SHALL have port: m_data  output  8  AXI-Stream TDATA.
REQ-013 SHALL have port: m_sof  output  1  TUSER; first pixel of frame.
REQ-014 SHALL have port: m_last  output  1  TLAST; final pixel of frame (frame end).
REQ-015 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port: frame_done  output  1  one-cycle pulse when final pixel leaves.
REQ-017 SHALL have port: frame_count  output  16  frames fully transmitted, wraps at 16'hFFFF -> 0.

Function
REQ-018 SHALL implement FSM states IDLE, SEND, DRAIN.
REQ-019 In IDLE, start with width!=0 and height!=0 SHALL latch width/height, clear col/row counters and enter SEND next cycle; start with a zero dimension SHALL be ignored.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 pix_ready SHALL be 1 only in SEND while the output buffer holds fewer than 2 entries; otherwise 0.
REQ-022 Each upstream acceptance SHALL write {pix_data, sof, last} into a 2-entry FIFO/skid buffer; sof=1 when col==0 && row==0; last=1 when col==w-1 && row==h-1.
REQ-023 col SHALL increment per acceptance, wrap to 0 at w-1 and increment row; counter widths SHALL be 11 and 10 bits.
REQ-024 Accepting the last pixel SHALL move SEND -> DRAIN; no pixel is accepted in DRAIN.
REQ-025 m_valid SHALL equal buffer-non-empty; m_data/m_sof/m_last SHALL show the head entry and remain stable while m_valid && !m_ready.
REQ-026 m_valid SHALL never drop without a transfer (m_valid && m_ready).
REQ-027 Latency SHALL be 1 cycle: a pixel accepted at edge N is presented on m_* after edge N.
REQ-028 Simultaneous upstream accept and downstream transfer SHALL preserve occupancy and ordering, sustaining 1 pixel/cycle when m_ready stays high.
REQ-029 In DRAIN, the transfer of the m_last entry SHALL pulse frame_done the next cycle and increment frame_count.
REQ-030 At that transfer, cont=1 SHALL re-enter SEND with the same latched dimensions and cleared counters; cont=0 SHALL enter IDLE.
REQ-031 With w=1,h=1 the single pixel SHALL carry m_sof=1 and m_last=1.
REQ-032 Input width/height changes after start SHALL not affect the frame in progress.

Reset
REQ-033 rst SHALL immediately force IDLE, empty the buffer, and clear counters and frame_count.
REQ-034 During reset, outputs SHALL be 0: m_valid, m_data, m_sof, m_last, pix_ready, busy, frame_done.
REQ-035 Reset mid-frame SHALL discard buffered pixels without asserting m_last or frame_done.

Verification
REQ-036 Bench SHALL cover: w=4,h=2, start, pix_valid=1, m_ready=1 -> 8 beats on consecutive cycles; sof on beat 0, last on beat 7; frame_done one cycle later; frame_count=1.
REQ-037 Bench SHALL cover: same frame with m_ready toggling 1,0 -> m_data stable across stalls, no loss or duplication, pix_ready=0 when 2 entries are buffered.
REQ-038 Bench SHALL cover: w=1,h=1 -> one beat with sof=last=1; busy returns 0.
REQ-039 Bench SHALL cover: start with width=0 -> remains IDLE, busy=0.
REQ-040 Bench SHALL cover: cont=1, w=3,h=1 -> back-to-back frames; sof every 3rd beat; frame_count increments per frame.
REQ-041 Bench SHALL cover: rst asserted after beat 2 of a w=4,h=2 frame -> m_valid=0 immediately, frame_count=0, no frame_done.

Source files
------------

// File: rtl/frame_stream_tx.sv
// Frame-oriented pixel source: counts width x height pixels per frame from an
// upstream valid/ready port into an AXI-Stream master through a 2-entry buffer.
module frame_stream_tx (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        cont,
   input  logic [10:0] width,
   input  logic [9:0]  height,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [7:0]  pix_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  m_data,
   output logic        m_sof,
   output logic        m_last,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_count
);

   typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [10:0] w_q, col_q, col_d;
   logic [9:0]  h_q, row_q, row_d;
   logic [9:0]  buf_q [2];
   logic        wr_ptr_q, rd_ptr_q;
   logic [1:0]  cnt_q;
   logic [15:0] fc_q;
   logic        fd_q;

   logic       accept, xfer, start_ok, restart, last_out;
   logic       pix_sof, pix_last;
   logic [9:0] head;

   assign head     = buf_q[rd_ptr_q];
   assign accept   = pix_valid && pix_ready;
   assign xfer     = m_valid && m_ready;
   assign start_ok = (state_q == IDLE) && start && (width != '0) && (height != '0);
   assign last_out = xfer && head[0];
   assign restart  = (state_q == DRAIN) && last_out && cont;
   assign pix_sof  = (col_q == '0) && (row_q == '0);
   assign pix_last = (col_q == w_q - 11'd1) && (row_q == h_q - 10'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = SEND;
         SEND:    if (accept && pix_last) state_d = DRAIN;
         DRAIN:   if (last_out) state_d = cont ? SEND : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != IDLE);
      pix_ready = (state_q == SEND) && (cnt_q != 2'd2);
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (start_ok || restart) begin
         col_d = '0;
         row_d = '0;
      end else if (accept) begin
         if (col_q == w_q - 11'd1) begin
            col_d = '0;
            row_d = row_q + 10'd1;
         end else begin
            col_d = col_q + 11'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q      <= '0;
         h_q      <= '0;
         col_q    <= '0;
         row_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= '0;
         fc_q     <= '0;
         fd_q     <= 1'b0;
      end else begin
         if (start_ok) begin
            w_q <= width;
            h_q <= height;
         end
         col_q <= col_d;
         row_q <= row_d;
         if (accept) wr_ptr_q <= ~wr_ptr_q;
         if (xfer)   rd_ptr_q <= ~rd_ptr_q;
         case ({accept, xfer})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
         fd_q <= last_out;
         if (last_out) fc_q <= fc_q + 16'd1;
      end
   end

   // Storage needs no reset: the head is masked whenever the buffer is empty.
   always_ff @(posedge clk) begin
      if (accept) buf_q[wr_ptr_q] <= {pix_data, pix_sof, pix_last};
   end

   assign m_valid     = (cnt_q != '0);
   assign m_data      = m_valid ? head[9:2] : '0;
   assign m_sof       = m_valid && head[1];
   assign m_last      = m_valid && head[0];
   assign frame_done  = fd_q;
   assign frame_count = fc_q;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Randomized bench for frame_stream_tx; a queue of expected beats built from
// frame geometry predicts every output each cycle.
module tb_frame_stream_tx;

   logic        clk = 1'b0;
   logic        rst, start, cont, pix_valid, m_ready;
   logic [10:0] width;
   logic [9:0]  height;
   logic [7:0]  pix_data;
   logic        pix_ready, m_valid, m_sof, m_last, busy, frame_done;
   logic [7:0]  m_data;
   logic [15:0] frame_count;

   frame_stream_tx dut (
      .clk(clk), .rst(rst), .start(start), .cont(cont),
      .width(width), .height(height),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_sof(m_sof), .m_last(m_last), .busy(busy),
      .frame_done(frame_done), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       sof;
      logic       last;
   } beat_t;

   int          checks = 0;
   int          passes = 0;
   beat_t       exp_q[$];
   logic [15:0] exp_fc = '0;
   int          beats, first_c, last_c;

   // Runs frames of w x h pixels; returns after the cycle following the final
   // frame end, or early once stop_beats beats have been transferred.
   task automatic run_stream(input int w, input int h, input int nf, input int vmode,
                             input int rmode, input int stop_beats, input int budget);
      int    n = w * h;
      int    acc_n = 0;
      int    done_n = 0;
      bit    active = 1'b1;
      bit    fd_exp = 1'b0;
      bit    fin = 1'b0;
      bit    ended = 1'b0;
      bit    exp_pr, exp_mv, acc, xf;
      beat_t hd;
      beats = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         exp_mv = (exp_q.size() != 0);
         exp_pr = active && (acc_n < n) && (exp_q.size() < 2);
         checks++; if (frame_done !== fd_exp) $display("FAIL frame_done c=%0d got %b exp %b", c, frame_done, fd_exp); else passes++;
         checks++; if (frame_count !== exp_fc) $display("FAIL frame_count c=%0d got %0d exp %0d", c, frame_count, exp_fc); else passes++;
         checks++; if (busy !== active) $display("FAIL busy c=%0d got %b exp %b", c, busy, active); else passes++;
         checks++; if (m_valid !== exp_mv) $display("FAIL m_valid c=%0d got %b exp %b", c, m_valid, exp_mv); else passes++;
         checks++; if (pix_ready !== exp_pr) $display("FAIL pix_ready c=%0d got %b exp %b", c, pix_ready, exp_pr); else passes++;
         if (exp_mv) begin
            checks++;
            if ({m_data, m_sof, m_last} !== exp_q[0])
               $display("FAIL head c=%0d got d=%h sof=%b last=%b exp d=%h sof=%b last=%b",
                        c, m_data, m_sof, m_last, exp_q[0].d, exp_q[0].sof, exp_q[0].last);
            else passes++;
         end
         if (fin || (stop_beats >= 0 && beats == stop_beats)) begin
            ended = 1'b1;
            break;
         end
         fd_exp    = 1'b0;
         start     = 1'b0;
         width     = 11'($urandom);
         height    = 10'($urandom);
         pix_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         pix_data  = 8'($urandom);
         m_ready   = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
         cont      = (done_n < nf - 1);
         acc = pix_valid && exp_pr;
         xf  = exp_mv && m_ready;
         if (xf) begin
            hd = exp_q.pop_front();
            if (beats == 0) first_c = c;
            last_c = c;
            beats++;
            if (hd.last) begin
               done_n++;
               exp_fc++;
               fd_exp = 1'b1;
               if (done_n < nf) acc_n = 0;
               else begin
                  active = 1'b0;
                  fin    = 1'b1;
               end
            end
         end
         if (acc) begin
            exp_q.push_back({pix_data, acc_n == 0, acc_n == n - 1});
            acc_n++;
         end
      end
      checks++; if (!ended) $display("FAIL timeout w=%0d h=%0d beats=%0d", w, h, beats); else passes++;
      pix_valid = 1'b0;
      m_ready   = 1'b0;
      cont      = 1'b0;
   endtask

   task automatic do_start(input int w, input int h);
      @(negedge clk);
      start     = 1'b1;
      width     = 11'(w);
      height    = 10'(h);
      pix_valid = 1'b0;
      m_ready   = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; cont = 1'b0; pix_valid = 1'b1; m_ready = 1'b1;
      width = 11'd4; height = 10'd2; pix_data = 8'hA5;
      #1;
      checks++; if ({m_valid, m_data, m_sof, m_last, pix_ready, busy, frame_done} !== 13'd0)
         $display("FAIL reset_outputs got v=%b d=%h s=%b l=%b pr=%b b=%b fd=%b exp all 0",
                  m_valid, m_data, m_sof, m_last, pix_ready, busy, frame_done);
      else passes++;
      checks++; if (frame_count !== 16'd0) $display("FAIL reset_fc got %0d exp 0", frame_count); else passes++;
      repeat (2) @(negedge clk);
      rst = 1'b0; pix_valid = 1'b0; m_ready = 1'b0;
   endtask

   task automatic test_basic;
      do_start(4, 2);
      run_stream(4, 2, 1, 0, 0, -1, 100);
      checks++; if (beats !== 8) $display("FAIL basic_beats got %0d exp 8", beats); else passes++;
      checks++; if (last_c - first_c !== 7) $display("FAIL basic_consecutive got span %0d exp 7", last_c - first_c); else passes++;
      checks++; if (frame_count !== 16'd1) $display("FAIL basic_fc got %0d exp 1", frame_count); else passes++;
   endtask

   task automatic test_stall;
      do_start(4, 2);
      run_stream(4, 2, 1, 0, 1, -1, 200);
      checks++; if (beats !== 8) $display("FAIL stall_beats got %0d exp 8", beats); else passes++;
   endtask

   task automatic test_single;
      do_start(1, 1);
      run_stream(1, 1, 1, 0, 0, -1, 50);
      checks++; if (beats !== 1) $display("FAIL single_beats got %0d exp 1", beats); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL single_busy got %b exp 0", busy); else passes++;
   endtask

   task automatic test_zero_width;
      do_start(0, 5);
      pix_valid = 1'b1;
      m_ready   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b0;
         checks++; if ({busy, pix_ready, m_valid} !== 3'b000)
            $display("FAIL zero_width got busy=%b pr=%b mv=%b exp 000", busy, pix_ready, m_valid);
         else passes++;
      end
      pix_valid = 1'b0;
   endtask

   task automatic test_back_to_back;
      do_start(3, 1);
      run_stream(3, 1, 4, 0, 0, -1, 200);
      checks++; if (beats !== 12) $display("FAIL b2b_beats got %0d exp 12", beats); else passes++;
   endtask

   task automatic test_random;
      for (int t = 0; t < 12; t++) begin
         int w = $urandom_range(1, 5);
         int h = $urandom_range(1, 3);
         do_start(w, h);
         run_stream(w, h, $urandom_range(1, 3), 1, 2, -1, 600);
      end
   endtask

   task automatic test_mid_reset;
      do_start(4, 2);
      run_stream(4, 2, 1, 0, 0, 3, 100);
      pix_valid = 1'b1;
      m_ready   = 1'b0;
      rst       = 1'b1;
      exp_q.delete();
      exp_fc = '0;
      #1;
      checks++; if ({m_valid, m_last, busy, pix_ready, frame_done} !== 5'd0)
         $display("FAIL midrst_outputs got mv=%b ml=%b b=%b pr=%b fd=%b exp 0",
                  m_valid, m_last, busy, pix_ready, frame_done);
      else passes++;
      checks++; if (frame_count !== exp_fc) $display("FAIL midrst_fc got %0d exp 0", frame_count); else passes++;
      m_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if ({m_valid, m_last, frame_done} !== 3'b000)
            $display("FAIL midrst_hold got mv=%b ml=%b fd=%b exp 000", m_valid, m_last, frame_done);
         else passes++;
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if ({m_valid, frame_done, busy} !== 3'b000 || frame_count !== 16'd0)
            $display("FAIL midrst_after got mv=%b fd=%b b=%b fc=%0d exp 0", m_valid, frame_done, busy, frame_count);
         else passes++;
      end
      pix_valid = 1'b0;
      m_ready   = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_single();
      test_zero_width();
      test_back_to_back();
      test_random();
      test_mid_reset();
      test_basic();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
